// File: rtl/seven_seg_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared constants and types for the seven-segment scanner.
//  Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

   localparam int         NUM_DIGITS  = 4;
   localparam logic [3:0] ANODE_OFF   = 4'b1111;
   localparam logic [6:0] CATHODE_OFF = 7'b1111111;

   typedef logic [1:0] digit_idx_t;
   typedef logic [6:0] segs_t;

   // Active-low one-hot anode mask for the given digit.
   function automatic logic [3:0] anode_for(input digit_idx_t idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scanner_if.sv
`default_nettype none
// ============================================================================
//  Interface : seven_seg_scanner_if
//  Purpose   : Value/load inputs and display-pin outputs of the scanner.
//              master = scanner (producer of anode select), slave = consumer.
//  Revision  : 1.0 - initial release
// ============================================================================
interface seven_seg_scanner_if;
   import seg7_pkg::*;

   logic [15:0] value;
   logic        load;
   digit_idx_t  digit_sel;
   logic [3:0]  anode;
   segs_t       cathode;
   logic        frame_done;

   modport master (
      input  value,
      input  load,
      output digit_sel,
      output anode,
      output cathode,
      output frame_done
   );

   modport slave (
      output value,
      output load,
      input  digit_sel,
      input  anode,
      input  cathode,
      input  frame_done
   );

endinterface
`default_nettype wire

// File: rtl/seven_seg_scanner_hex_to_cathode.sv
`default_nettype none
// ============================================================================
//  Module   : hex_to_cathode
//  Purpose  : Combinational hex nibble to active-low {g,f,e,d,c,b,a} decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module hex_to_cathode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   output segs_t      segs_o
);

   // Full 0-F glyph set, lower-case b and d so they differ from 8 and 0.
   always_comb begin
      segs_o = CATHODE_OFF;
      case (nibble_i)
         4'h0: segs_o = 7'b1000000;
         4'h1: segs_o = 7'b1111001;
         4'h2: segs_o = 7'b0100100;
         4'h3: segs_o = 7'b0110000;
         4'h4: segs_o = 7'b0011001;
         4'h5: segs_o = 7'b0010010;
         4'h6: segs_o = 7'b0000010;
         4'h7: segs_o = 7'b1111000;
         4'h8: segs_o = 7'b0000000;
         4'h9: segs_o = 7'b0010000;
         4'hA: segs_o = 7'b0001000;
         4'hB: segs_o = 7'b0000011;
         4'hC: segs_o = 7'b1000110;
         4'hD: segs_o = 7'b0100001;
         4'hE: segs_o = 7'b0000110;
         4'hF: segs_o = 7'b0001110;
         default: segs_o = CATHODE_OFF;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scanner
//  Purpose  : 4-digit time-multiplexed seven-segment driver with a
//             double-buffered 16-bit hex value. All outputs registered.
//  Options  : SCANNER_DEADTIME_EN - blank anodes/cathodes for the first
//             DEADTIME cycles of every digit slot.
//  Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scanner
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int DEADTIME    = 8
)
(
   input  logic                clk,
   input  logic                reset,
   seven_seg_scanner_if.master scan
);

   localparam int              PW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0]   DEAD_LIMIT = PW'(DEADTIME);
`ifdef SCANNER_DEADTIME_EN
   localparam bit              DEAD_EN    = 1'b1;
`else
   localparam bit              DEAD_EN    = 1'b0;
`endif
   localparam digit_idx_t      LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

   logic [PW-1:0] presc_q, presc_d;
   digit_idx_t    digit_q, digit_d;
   logic [15:0]   shadow_q, shadow_d;
   logic [15:0]   active_q, active_d;
   logic [3:0]    anode_q;
   segs_t         cathode_q;
   logic          frame_done_q;

   logic          term_cnt;
   logic          wrap;
   logic          blank;
   logic [3:0]    sel_nibble;
   segs_t         dec_segs;

   // Next-state: prescaler, digit index and the shadow/active double buffer.
   // Outputs are decoded from next-state values so anode, cathode and
   // digit_sel all move on the same edge.
   always_comb begin
      term_cnt = (presc_q == PRESC_LAST);
      wrap     = term_cnt && (digit_q == LAST_DIGIT);
      presc_d  = term_cnt ? '0 : presc_q + 1'b1;
      digit_d  = term_cnt ? digit_idx_t'(digit_q + 1'b1) : digit_q;
      shadow_d = scan.load ? scan.value : shadow_q;
      // A load on the wrap edge reaches the display immediately via shadow_d.
      active_d = wrap ? shadow_d : active_q;
      blank    = DEAD_EN && (presc_d < DEAD_LIMIT);
      case (digit_d)
         2'd0:    sel_nibble = active_d[3:0];
         2'd1:    sel_nibble = active_d[7:4];
         2'd2:    sel_nibble = active_d[11:8];
         default: sel_nibble = active_d[15:12];
      endcase
   end

   hex_to_cathode u_dec (
      .nibble_i (sel_nibble),
      .segs_o   (dec_segs)
   );

   // State and registered display outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q      <= '0;
         digit_q      <= '0;
         shadow_q     <= '0;
         active_q     <= '0;
         anode_q      <= ANODE_OFF;
         cathode_q    <= CATHODE_OFF;
         frame_done_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         digit_q      <= digit_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         anode_q      <= blank ? ANODE_OFF   : anode_for(digit_d);
         cathode_q    <= blank ? CATHODE_OFF : dec_segs;
         frame_done_q <= wrap;
      end
   end

   assign scan.digit_sel  = digit_q;
   assign scan.anode      = anode_q;
   assign scan.cathode    = cathode_q;
   assign scan.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_scanner
//  Purpose  : Self-checking bench for seven_seg_scanner (REFRESH_DIV=4,
//             DEADTIME=2). Expected outputs come from a cycle-count model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scanner;

   localparam int RDIV = 4;
   localparam int DT   = 2;
   localparam int SLOT = RDIV;
   localparam int FRAME = 4 * RDIV;
`ifdef SCANNER_DEADTIME_EN
   localparam bit DEAD = 1'b1;
`else
   localparam bit DEAD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   // Model state: edges since reset release, pending and displayed values.
   int          t;
   logic [15:0] pending;
   logic [15:0] shown;

   logic [6:0] glyph [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   seven_seg_scanner_if dif ();

   seven_seg_scanner #(.REFRESH_DIV(RDIV), .DEADTIME(DT)) dut (
      .clk   (clk),
      .reset (reset),
      .scan  (dif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
      end
   endtask

   // Compare every output against what the cycle count and shown value imply.
   task automatic check_model();
      int          dig;
      logic        blank;
      logic [3:0]  an_exp;
      logic [6:0]  ca_exp;
      logic [3:0]  nib;
      dig    = (t / SLOT) % 4;
      blank  = DEAD && (t > 0 || 1'b1) && ((t % SLOT) < DT);
      nib    = 4'((shown >> (4 * dig)) & 16'hF);
      an_exp = 4'b1111;
      an_exp[dig] = 1'b0;
      ca_exp = glyph[nib];
      if (blank) begin
         an_exp = 4'b1111;
         ca_exp = 7'h7F;
      end
      check("digit_sel",  16'(dif.digit_sel),  16'(dig));
      check("anode",      16'(dif.anode),      16'(an_exp));
      check("cathode",    16'(dif.cathode),    16'(ca_exp));
      check("frame_done", 16'(dif.frame_done), 16'(t > 0 && (t % FRAME) == 0));
   endtask

   task automatic tick();
      logic ld;
      logic [15:0] v;
      ld = dif.load;
      v  = dif.value;
      @(posedge clk);
      t++;
      if (ld) pending = v;
      if ((t % FRAME) == 0) shown = pending;
      #1;
      check_model();
   endtask

   task automatic go_to(input int target);
      while (t < target) tick();
   endtask

   task automatic do_load(input logic [15:0] v);
      dif.load  = 1'b1;
      dif.value = v;
      tick();
      dif.load  = 1'b0;
      dif.value = 16'($urandom);
   endtask

   task automatic check_off(input string tag);
      check({tag, "_anode"},   16'(dif.anode),      16'h000F);
      check({tag, "_cathode"}, 16'(dif.cathode),    16'h007F);
      check({tag, "_digit"},   16'(dif.digit_sel),  16'h0000);
      check({tag, "_fdone"},   16'(dif.frame_done), 16'h0000);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset   = 1'b0;
      t       = 0;
      pending = 16'h0000;
      shown   = 16'h0000;
   endtask

   initial begin
      reset     = 1'b1;
      dif.load  = 1'b0;
      dif.value = 16'h0000;
      t         = 0;
      pending   = 16'h0000;
      shown     = 16'h0000;
      #3;
      check_off("reset");
      repeat (3) @(posedge clk);
      release_reset();

      // First edge after release drives digit 0 with value 0.
      tick();

      // Mid-frame load stays invisible until the next wrap.
      go_to(5);
      do_load(16'h8F10);
      go_to(FRAME - 1);
      check("old_frame_cathode", 16'(dif.cathode), 16'h0040);
      for (int d = 0; d < 4; d++) begin
         go_to(FRAME + d * SLOT + SLOT - 1);
         check("8F10_digit", 16'(dif.cathode), 16'(glyph[(16'h8F10 >> (4 * d)) & 16'hF]));
      end

      // Last load in a frame wins.
      go_to(2 * FRAME + 3);
      do_load(16'h1111);
      go_to(2 * FRAME + 8);
      do_load(16'h2222);
      go_to(3 * FRAME + SLOT - 1);
      check("last_load_wins", 16'(dif.cathode), 16'h0024);

      // Load exactly on the wrap edge is shown on that frame's digit 0.
      go_to(4 * FRAME - 1);
      do_load(16'hFFFF);
      check("wrap_fdone", 16'(dif.frame_done), 16'h0001);
      go_to(4 * FRAME + SLOT - 1);
      check("wrap_load_digit0", 16'(dif.cathode), 16'h000E);

      // Random loads.
      for (int i = 0; i < 200; i++) begin
         if (($urandom % 6) == 0) do_load(16'($urandom));
         else tick();
      end

      // Reset mid-frame with a pending shadow value.
      go_to(((t / FRAME) + 1) * FRAME + 5);
      do_load(16'hA5C3);
      #2;
      reset = 1'b1;
      #1;
      check_off("async_reset");
      @(posedge clk);
      #1;
      check_off("held_reset");
      release_reset();
      go_to(FRAME + SLOT - 1);
      check("pending_lost", 16'(dif.cathode), 16'h0040);

      // More random traffic after reset.
      for (int i = 0; i < 150; i++) begin
         if (($urandom % 5) == 0) do_load(16'($urandom));
         else tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
